// File: rtl/spi_pkg.sv
// Shared SPI arbitration definitions: FSM state encoding, byte width and
// the default WAIT watchdog length.
package spi_pkg;

   localparam int SPI_BYTE_W          = 8;
   localparam int SPI_DEFAULT_TIMEOUT = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector. Scans the request vector
// starting at ptr and wrapping modulo N; returns the first set request as
// a one-hot vector plus its index. valid is low when nothing is requesting.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Walk the offsets from ptr upward; the first requesting slot wins.
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!valid && req[j] && (((int'(ptr) + i) % N) == j)) begin
               onehot[j] = 1'b1;
               idx       = IDX_W'(j);
               valid     = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter and byte sequencer in front of the shared 8-bit SPI
// master. One requester owns the master at a time and may hold it for a
// multi-byte burst; ownership then rotates.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
   import spi_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = SPI_DEFAULT_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [SPI_BYTE_W*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            byte_done,
   output logic [SPI_BYTE_W-1:0]         spi_tx_data,
   output logic                          spi_tx_start,
   input  logic                          spi_tx_done,
   output logic                          busy,
   output logic [$clog2(NUM_REQ)-1:0]    owner,
   output logic                          timeout_err
);

   localparam int IDX_W = $clog2(NUM_REQ);

   generate
      if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
         $error("spi_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
      end
   endgenerate

   arb_state_t             state;
   arb_state_t             state_next;
   logic [IDX_W-1:0]       rr_ptr;
   logic [IDX_W-1:0]       next_ptr;
   logic                   last_q;

   logic [NUM_REQ-1:0]     pick_onehot;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_valid;

   logic [IDX_W-1:0]       mux_idx;
   logic [SPI_BYTE_W-1:0]  mux_data;
   logic                   mux_last;
   logic                   owner_req;

   logic                   do_grant;
   logic                   do_next;
   logic                   do_release;
   logic                   timeout_hit;

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req    (req),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   assign busy     = |gnt;
   assign mux_idx  = (state == IDLE) ? pick_idx : owner;
   assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

   // Select the byte/last flag of the incoming winner in IDLE, or of the
   // current owner in HOLD, and the owner's own request line.
   always_comb begin
      mux_data  = '0;
      mux_last  = 1'b0;
      owner_req = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (mux_idx == IDX_W'(i)) begin
            mux_data = req_data[i*SPI_BYTE_W +: SPI_BYTE_W];
            mux_last = req_last[i];
         end
         if (owner == IDX_W'(i)) begin
            owner_req = req[i];
         end
      end
   end

   // Completion pulse goes straight back to the owner in the cycle the
   // master reports done, so the requester can update on that same edge.
   always_comb begin
      byte_done = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         byte_done[i] = (state == WAIT) && spi_tx_done && (owner == IDX_W'(i));
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_q;

   // Watchdog restarts on every WAIT entry and counts cycles spent waiting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (do_grant || do_next) begin
         wait_cnt <= '0;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Abort pulse; a done arriving on the expiry cycle takes precedence.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_hit && !spi_tx_done;
      end
   end

   assign timeout_err = timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the grant/next-byte/release decisions that steer
   // the datapath registers.
   always_comb begin
      state_next = state;
      do_grant   = 1'b0;
      do_next    = 1'b0;
      do_release = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               do_grant   = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (spi_tx_done) begin
               if (last_q) begin
                  do_release = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = HOLD;
               end
            end else if (timeout_hit) begin
               do_release = 1'b1;
               state_next = IDLE;
            end
         end
         HOLD: begin
            if (owner_req) begin
               do_next    = 1'b1;
               state_next = WAIT;
            end else begin
               do_release = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Grant, owner, byte and start registers; release rotates the pointer
   // past the owner that just finished or was dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt          <= '0;
         owner        <= '0;
         spi_tx_data  <= '0;
         spi_tx_start <= 1'b0;
         last_q       <= 1'b0;
         rr_ptr       <= '0;
      end else begin
         spi_tx_start <= 1'b0;
         if (do_grant) begin
            gnt          <= pick_onehot;
            owner        <= pick_idx;
            spi_tx_data  <= mux_data;
            last_q       <= mux_last;
            spi_tx_start <= 1'b1;
         end else if (do_next) begin
            spi_tx_data  <= mux_data;
            last_q       <= mux_last;
            spi_tx_start <= 1'b1;
         end
         if (do_release) begin
            gnt    <= '0;
            rr_ptr <= next_ptr;
         end
      end
   end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: single byte, round-robin fairness,
// burst hold, abandoned burst, reset during WAIT and the WAIT watchdog
// (behaviour follows SPI_ARB_TIMEOUT_EN). Expected bytes are queued when a
// requester presents them and popped whenever the arbiter starts a byte.
module tb_spi_req_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]  req_last;
   logic [N-1:0]  gnt;
   logic [N-1:0]  byte_done;
   logic [7:0]    spi_tx_data;
   logic          spi_tx_start;
   logic          spi_tx_done;
   logic          busy;
   logic [1:0]    owner;
   logic          timeout_err;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   spi_req_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_data     (req_data),
      .req_last     (req_last),
      .gnt          (gnt),
      .byte_done    (byte_done),
      .spi_tx_data  (spi_tx_data),
      .spi_tx_start (spi_tx_start),
      .spi_tx_done  (spi_tx_done),
      .busy         (busy),
      .owner        (owner),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic driveReq(input int idx, input logic [7:0] data, input logic last);
      req[idx]            = 1'b1;
      req_data[idx*8 +: 8] = data;
      req_last[idx]       = last;
   endtask

   task automatic expectByte(input int idx, input logic [7:0] data);
      exp_t e;
      e.idx  = idx;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic applyStimulus(input int idx, input logic [7:0] data, input logic last);
      driveReq(idx, data, last);
      expectByte(idx, data);
   endtask

   // Move out of the start cycle, confirm the pulse was one cycle wide,
   // then raise tx_done and check the owner's byte_done pulse.
   task automatic pulseDone(input int idx, input string tag);
      tick();
      checkOutput({tag, " start width"}, spi_tx_start, 0);
      spi_tx_done = 1'b1;
      #1;
      checkOutput({tag, " byte_done"}, byte_done, 32'(1) << idx);
   endtask

   task automatic endDone();
      tick();
      spi_tx_done = 1'b0;
   endtask

   // Scoreboard: every start pulse must match the oldest queued byte/owner.
   always @(negedge clk) begin
      if (reset === 1'b0 && spi_tx_start === 1'b1) begin
         if (exp_q.size() == 0) begin
            checkOutput("sb unexpected start", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("sb data", spi_tx_data, e.data);
            checkOutput("sb gnt", gnt, 32'(1) << e.idx);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global time limit reached");
      $fatal(1, "[TB] stopping");
   end

   initial begin
      reset       = 1'b1;
      req         = '0;
      req_last    = '0;
      req_data    = '0;
      spi_tx_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset values
      checkOutput("rst gnt", gnt, 0);
      checkOutput("rst byte_done", byte_done, 0);
      checkOutput("rst tx_data", spi_tx_data, 0);
      checkOutput("rst tx_start", spi_tx_start, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst owner", owner, 0);
      checkOutput("rst timeout_err", timeout_err, 0);
      reset = 1'b0;
      tick();

      // Single byte from requester 0
      $display("[TB] single byte");
      applyStimulus(0, 8'hA5, 1'b1);
      tick();
      checkOutput("single start", spi_tx_start, 1);
      checkOutput("single gnt", gnt, 4'b0001);
      checkOutput("single busy", busy, 1);
      checkOutput("single tx_data", spi_tx_data, 8'hA5);
      pulseDone(0, "single");
      req[0] = 1'b0;
      endDone();
      checkOutput("single rel gnt", gnt, 0);
      checkOutput("single rel busy", busy, 0);
      checkOutput("single rr_ptr", dut.rr_ptr, 1);

      // Fairness from reset: 0 then 2, then 3 before 1
      $display("[TB] fairness");
      reset = 1'b1;
      #1;
      reset = 1'b0;
      checkOutput("fair rr_ptr reset", dut.rr_ptr, 0);
      applyStimulus(0, 8'h10, 1'b1);
      applyStimulus(2, 8'h12, 1'b1);
      tick();
      checkOutput("fair gnt0", gnt, 4'b0001);
      pulseDone(0, "fair0");
      req[0] = 1'b0;
      endDone();
      checkOutput("fair gap gnt", gnt, 0);
      tick();
      checkOutput("fair start2", spi_tx_start, 1);
      checkOutput("fair gnt2", gnt, 4'b0100);
      pulseDone(2, "fair2");
      req[2] = 1'b0;
      endDone();
      checkOutput("fair rr_ptr3", dut.rr_ptr, 3);
      applyStimulus(3, 8'h23, 1'b1);
      applyStimulus(1, 8'h21, 1'b1);
      tick();
      checkOutput("fair gnt3", gnt, 4'b1000);
      pulseDone(3, "fair3");
      req[3] = 1'b0;
      endDone();
      tick();
      checkOutput("fair gnt1", gnt, 4'b0010);
      pulseDone(1, "fair1");
      req[1] = 1'b0;
      endDone();

      // Burst on requester 1 while requester 3 waits
      $display("[TB] burst");
      applyStimulus(1, 8'h11, 1'b0);
      tick();
      checkOutput("burst start0", spi_tx_start, 1);
      checkOutput("burst gnt0", gnt, 4'b0010);
      driveReq(3, 8'h44, 1'b1);
      pulseDone(1, "burst0");
      applyStimulus(1, 8'h22, 1'b0);
      endDone();
      checkOutput("burst hold start", spi_tx_start, 0);
      checkOutput("burst hold gnt", gnt, 4'b0010);
      tick();
      checkOutput("burst start1", spi_tx_start, 1);
      pulseDone(1, "burst1");
      applyStimulus(1, 8'h33, 1'b1);
      endDone();
      tick();
      checkOutput("burst start2", spi_tx_start, 1);
      checkOutput("burst gnt2", gnt, 4'b0010);
      pulseDone(1, "burst2");
      req[1] = 1'b0;
      expectByte(3, 8'h44);
      endDone();
      checkOutput("burst rel gnt", gnt, 0);
      checkOutput("burst rel busy", busy, 0);
      tick();
      checkOutput("burst next start", spi_tx_start, 1);
      checkOutput("burst next gnt", gnt, 4'b1000);
      pulseDone(3, "burst3");
      req[3] = 1'b0;
      endDone();

      // Abandoned burst on requester 2
      $display("[TB] abandon");
      applyStimulus(2, 8'h55, 1'b0);
      tick();
      checkOutput("aband gnt", gnt, 4'b0100);
      pulseDone(2, "aband");
      req[2] = 1'b0;
      endDone();
      checkOutput("aband hold busy", busy, 1);
      tick();
      checkOutput("aband rel gnt", gnt, 0);
      checkOutput("aband rel busy", busy, 0);
      checkOutput("aband rel start", spi_tx_start, 0);
      checkOutput("aband rr_ptr", dut.rr_ptr, 3);

      // Reset while in WAIT, then a late tx_done
      $display("[TB] reset mid-wait");
      applyStimulus(0, 8'h77, 1'b1);
      tick();
      checkOutput("rstw gnt", gnt, 4'b0001);
      tick();
      reset = 1'b1;
      #1;
      checkOutput("rstw gnt", gnt, 0);
      checkOutput("rstw busy", busy, 0);
      checkOutput("rstw owner", owner, 0);
      checkOutput("rstw tx_data", spi_tx_data, 0);
      checkOutput("rstw tx_start", spi_tx_start, 0);
      req[0] = 1'b0;
      tick();
      reset       = 1'b0;
      spi_tx_done = 1'b1;
      #1;
      checkOutput("rstw late byte_done", byte_done, 0);
      checkOutput("rstw late gnt", gnt, 0);
      endDone();

      // WAIT watchdog
      $display("[TB] watchdog");
      applyStimulus(1, 8'h99, 1'b1);
      driveReq(2, 8'hAA, 1'b1);
      tick();
      checkOutput("wdog gnt1", gnt, 4'b0010);
`ifdef SPI_ARB_TIMEOUT_EN
      for (int k = 1; k < 16; k++) begin
         tick();
         checkOutput("wdog early err", timeout_err, 0);
      end
      checkOutput("wdog pre gnt", gnt, 4'b0010);
      tick();
      checkOutput("wdog err pulse", timeout_err, 1);
      checkOutput("wdog rel gnt", gnt, 0);
      checkOutput("wdog rel busy", busy, 0);
      checkOutput("wdog no byte_done", byte_done, 0);
      expectByte(2, 8'hAA);
      tick();
      checkOutput("wdog err width", timeout_err, 0);
      checkOutput("wdog next start", spi_tx_start, 1);
      checkOutput("wdog next gnt", gnt, 4'b0100);
      pulseDone(2, "wdog2");
      req[1] = 1'b0;
      req[2] = 1'b0;
      endDone();
`else
      for (int k = 0; k < 30; k++) begin
         tick();
      end
      checkOutput("nowdog gnt held", gnt, 4'b0010);
      checkOutput("nowdog busy", busy, 1);
      checkOutput("nowdog err", timeout_err, 0);
      pulseDone(1, "nowdog1");
      req[1] = 1'b0;
      expectByte(2, 8'hAA);
      endDone();
      tick();
      checkOutput("nowdog next gnt", gnt, 4'b0100);
      pulseDone(2, "nowdog2");
      req[2] = 1'b0;
      endDone();
`endif

      tick();
      checkOutput("sb drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_req_arbiter.md
# spi_req_arbiter

Round-robin arbiter and byte sequencer that shares the single 8-bit SPI master among `NUM_REQ` on-chip requesters. It grants the master to one requester at a time and drives its `tx_data`/`tx_start`. It waits for `tx_done`, then either holds the grant for a multi-byte burst (one chip-select frame per byte on the master) or releases it. The block sits between the AHB-Lite register front-ends and the SPI master.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `TIMEOUT_CYCLES`, 1024: `clk` cycles allowed in WAIT before abort. Used only with `SPI_ARB_TIMEOUT_EN`.
- `clk` in 1: system clock (HCLK).
- `reset` in 1: asynchronous, active-high reset.
- `req` in NUM_REQ: per-requester request; held high while the requester has a byte pending.
- `req_data` in 8*NUM_REQ: byte for requester i at bits [8i+7:8i]; valid while `req[i]` is high.
- `req_last` in NUM_REQ: marks the presented byte as the last of the burst.
- `gnt` out NUM_REQ: one-hot grant, registered.
- `byte_done` out NUM_REQ: one-cycle pulse to the owner when its byte completes.
- `spi_tx_data` out 8: to master `tx_data`, registered.
- `spi_tx_start` out 1: to master `tx_start`, registered one-cycle pulse.
- `spi_tx_done` in 1: from master `tx_done`.
- `busy` out 1: high whenever any grant is held.
- `owner` out $clog2(NUM_REQ): index of the current or last owner.
- `timeout_err` out 1: one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, WAIT, HOLD. Reset state is IDLE.
- Reset values: `gnt`=0, `byte_done`=0, `spi_tx_data`=0x00, `spi_tx_start`=0, `busy`=0, `owner`=0, `timeout_err`=0, `rr_ptr`=0, `last_q`=0.
- IDLE, `|req`=1:
  - Winner is the first set `req` bit scanning from `rr_ptr` upward, wrapping modulo NUM_REQ.
  - At that edge: `gnt`/`owner` are set, `spi_tx_data` ← winner's byte, `last_q` ← `req_last[winner]`, `spi_tx_start` ← 1. Go to WAIT.
- WAIT, `spi_tx_done`=1:
  - `byte_done[owner]` is asserted combinationally in that cycle.
  - If `last_q`=1: clear `gnt`/`busy`, `rr_ptr` ← (owner+1) mod NUM_REQ, go to IDLE.
  - Otherwise go to HOLD.
- HOLD, `req[owner]`=1: capture the next byte and `req_last`, pulse `spi_tx_start`, go to WAIT.
- HOLD, `req[owner]`=0: release as above (requester abandoned the burst), go to IDLE.
- Requester protocol: update `req_data`/`req_last`/`req` at the edge where its `byte_done` is high. The arbiter samples them on the following edge in HOLD.
- `req` changes on non-owners during a grant are ignored; they never preempt.
- `spi_tx_done` outside WAIT is ignored.
- `spi_tx_start` is never issued outside IDLE→WAIT or HOLD→WAIT, so it never collides with an active master transfer.
- Asynchronous reset in any state returns immediately to the reset values. An in-flight master transfer is not the arbiter's concern.

## Timing
- Request to `spi_tx_start`: 1 edge. `req` sampled at edge N; `spi_tx_start` and `gnt` are high in cycle N+1.
- `spi_tx_start` width is exactly 1 cycle.
- Inter-byte gap within a burst: `byte_done` cycle + 1 HOLD edge, then `spi_tx_start`. This is 2 cycles after `spi_tx_done`.
- Release to next grant: `gnt` is low for at least 1 cycle (IDLE) between owners.
- Simultaneous events:
  - A new `req` in the same cycle as release is evaluated in the IDLE cycle against the updated `rr_ptr`.
  - `spi_tx_done` coincident with watchdog expiry: `spi_tx_done` wins, and no `timeout_err` is raised.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A WAIT-state counter, cleared on WAIT entry, counts cycles.
  - On reaching TIMEOUT_CYCLES without `spi_tx_done`: pulse `timeout_err`, release the owner (`rr_ptr` advance), go to IDLE. No `byte_done` is issued.
- Undefined: no counter. WAIT persists until `spi_tx_done`, and `timeout_err` is tied to 0.

## Structure
- The shared package `spi_pkg` holds:
  - the state enum constants (IDLE/WAIT/HOLD),
  - the byte width constant 8,
  - the default TIMEOUT_CYCLES.
- One sub-module, `rr_pick`: combinational round-robin priority selector (req vector + ptr → one-hot winner + index, valid). It is reusable by the future register-access arbiter.

## Test plan
- Single byte: `req[0]`=1, `req_data[0]`=0xA5, `req_last[0]`=1.
  - Expect `spi_tx_start` for 1 cycle with `spi_tx_data`=0xA5 and `gnt`=0001.
  - After `spi_tx_done`: `byte_done[0]` pulse, `gnt`=0, `busy`=0, `rr_ptr`=1.
- Fairness: from reset, `req[0]` and `req[2]` held with last=1 → grants 0 then 2. Then `req[1]` and `req[3]` → `rr_ptr`=3, so 3 is granted before 1.
- Burst: `req[1]` sends 0x11, 0x22, 0x33 with last on 0x33, while `req[3]` is asserted throughout.
  - Expect three `spi_tx_start` pulses in order, `gnt`=0010 held throughout, and `gnt[3]` only after 0x33 completes.
- Abandon: `req[2]` burst drops `req` after the first `byte_done` → HOLD releases to IDLE, `busy`=0, `rr_ptr`=3.
- Reset mid-WAIT: assert `reset` while in WAIT → all outputs return to reset values in the same cycle. A late `spi_tx_done` after reset produces no `byte_done`.
- Timeout (macro on, TIMEOUT_CYCLES=16): `spi_tx_done` held low → `timeout_err` pulse after 16 WAIT cycles, `gnt` clears, the next requester is granted. With the macro off, WAIT persists.
